mem_access_unit: RTL and testbench

//  Multi-cycle data-memory access engine for the MIPS datapath; successor to the combinational memory-control decode.

---
 rtl/mem_access_unit.sv | 203 ++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: multi-cycle MIPS load/store engine between the MEM stage and a wait-stated data memory.
// Latency: resp_valid two cycles after accept with an immediate ack; illegal/trapped requests respond the cycle after accept.
// Backpressure: req_ready only while idle; memory stalls via mem_ack, bounded by TIMEOUT; responses cannot be stalled.
// Build option: define MEM_ALIGN_TRAP_EN to fault misaligned accesses instead of force-aligning them.

`ifndef MEM_BYTE
`define MEM_BYTE 2'b00
`endif
`ifndef MEM_HALF
`define MEM_HALF 2'b01
`endif
`ifndef MEM_WORD
`define MEM_WORD 2'b10
`endif

module mem_access_unit #(
  parameter int ADDR_W     = 32,
  parameter int TIMEOUT    = 16,
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_read,
  input  logic              req_write,
  input  logic [1:0]        req_mode,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_fault,
  output logic [1:0]        resp_cause,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);

`ifdef MEM_ALIGN_TRAP_EN
  localparam bit ALIGN_TRAP = 1'b1;
`else
  localparam bit ALIGN_TRAP = 1'b0;
`endif

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b11;

  typedef enum logic [1:0] {IDLE, REQ, RESP, FAULT} state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic [1:0]       lat_mode;
  logic             lat_signed;
  logic             lat_read;
  logic [1:0]       lat_lane;

  logic              accept;
  logic              is_byte;
  logic              is_half;
  logic              misaligned;
  logic              illegal;
  logic [1:0]        off;
  logic [1:0]        lane;
  logic [3:0]        be_n;
  logic [31:0]       wdata_n;
  logic [ADDR_W-1:0] addr_n;
  logic [31:0]       shifted;
  logic [31:0]       load_ext;

  // Decode the incoming request: alignment, lowest byte lane, enables and replicated store data.
  always_comb begin
    is_byte    = (req_mode == `MEM_BYTE);
    is_half    = (req_mode == `MEM_HALF);
    accept     = req_valid & req_ready & (req_read | req_write);
    illegal    = req_read & req_write;
    misaligned = 1'b0;
    off        = req_addr[1:0];
    lane       = 2'd0;
    be_n       = 4'b1111;
    wdata_n    = req_wdata;
    addr_n     = {req_addr[ADDR_W-1:2], 2'b00};
    if (is_byte) begin
      lane    = BIG_ENDIAN ? (2'd3 - off) : off;
      be_n    = 4'b0001 << lane;
      wdata_n = {4{req_wdata[7:0]}};
    end else if (is_half) begin
      misaligned = req_addr[0];
      off[0]     = 1'b0;
      lane       = BIG_ENDIAN ? (2'd2 - off) : off;
      be_n       = 4'b0011 << lane;
      wdata_n    = {2{req_wdata[15:0]}};
    end else begin
      misaligned = |req_addr[1:0];
      off        = 2'd0;
    end
  end

  // Pull the addressed lane out of the returned word and extend it to 32 bits.
  always_comb begin
    shifted  = mem_rdata >> {lat_lane, 3'b000};
    load_ext = mem_rdata;
    if (lat_mode == `MEM_BYTE) begin
      load_ext = lat_signed ? {{24{shifted[7]}}, shifted[7:0]} : {24'd0, shifted[7:0]};
    end else if (lat_mode == `MEM_HALF) begin
      load_ext = lat_signed ? {{16{shifted[15]}}, shifted[15:0]} : {16'd0, shifted[15:0]};
    end
  end

  // Access FSM with all handshake, memory-port and response outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      lat_mode   <= 2'b00;
      lat_signed <= 1'b0;
      lat_read   <= 1'b0;
      lat_lane   <= 2'd0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_fault <= 1'b0;
      resp_cause <= 2'b00;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_be     <= 4'd0;
      mem_wdata  <= 32'd0;
    end else begin
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_fault <= 1'b0;
      resp_cause <= 2'b00;
      case (state)
        IDLE: begin
          if (accept) begin
            lat_mode   <= req_mode;
            lat_signed <= req_signed;
            lat_read   <= req_read;
            lat_lane   <= lane;
            wait_cnt   <= '0;
            req_ready  <= 1'b0;
            if (illegal || (ALIGN_TRAP && misaligned)) begin
              // Rejected requests never touch the memory port.
              state      <= FAULT;
              resp_valid <= 1'b1;
              resp_fault <= 1'b1;
              resp_cause <= illegal ? CAUSE_ILLEGAL : CAUSE_MISALIGN;
            end else begin
              state     <= REQ;
              mem_req   <= 1'b1;
              mem_we    <= req_write;
              mem_addr  <= addr_n;
              mem_be    <= be_n;
              mem_wdata <= req_write ? wdata_n : 32'd0;
            end
          end
        end
        REQ: begin
          // An ack in the last allowed cycle still completes normally.
          if (mem_ack) begin
            state      <= RESP;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_be     <= 4'd0;
            mem_wdata  <= 32'd0;
            resp_valid <= 1'b1;
            resp_rdata <= lat_read ? load_ext : 32'd0;
          end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
            state      <= FAULT;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_be     <= 4'd0;
            mem_wdata  <= 32'd0;
            resp_valid <= 1'b1;
            resp_fault <= 1'b1;
            resp_cause <= CAUSE_TIMEOUT;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        RESP, FAULT: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: little- and big-endian instances share stimulus; TIMEOUT=4.
// Table vectors with hand-computed results, randomized transactions against a byte-level model,
// and hand sequences for misalignment, ignored requests and reset during an access.
`timescale 1ns/1ps

`ifndef MEM_BYTE
`define MEM_BYTE 2'b00
`endif
`ifndef MEM_HALF
`define MEM_HALF 2'b01
`endif
`ifndef MEM_WORD
`define MEM_WORD 2'b10
`endif

module tb_mem_access_unit;
  localparam int TO = 4;
`ifdef MEM_ALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid = 0, req_read = 0, req_write = 0, req_signed = 0, mem_ack = 0;
  logic [1:0]  req_mode = 2'b00;
  logic [31:0] req_addr = 0, req_wdata = 0, mem_rdata = 0;

  logic        a_req_ready, a_resp_valid, a_resp_fault, a_mem_req, a_mem_we;
  logic [1:0]  a_resp_cause;
  logic [31:0] a_resp_rdata, a_mem_addr, a_mem_wdata;
  logic [3:0]  a_mem_be;
  logic        b_req_ready, b_resp_valid, b_resp_fault, b_mem_req, b_mem_we;
  logic [1:0]  b_resp_cause;
  logic [31:0] b_resp_rdata, b_mem_addr, b_mem_wdata;
  logic [3:0]  b_mem_be;

  mem_access_unit #(.ADDR_W(32), .TIMEOUT(TO), .BIG_ENDIAN(1'b0)) u_le (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(a_req_ready),
    .req_read(req_read), .req_write(req_write), .req_mode(req_mode), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(a_resp_valid), .resp_rdata(a_resp_rdata),
    .resp_fault(a_resp_fault), .resp_cause(a_resp_cause), .mem_req(a_mem_req), .mem_we(a_mem_we),
    .mem_addr(a_mem_addr), .mem_be(a_mem_be), .mem_wdata(a_mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack));

  mem_access_unit #(.ADDR_W(32), .TIMEOUT(TO), .BIG_ENDIAN(1'b1)) u_be (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(b_req_ready),
    .req_read(req_read), .req_write(req_write), .req_mode(req_mode), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(b_resp_valid), .resp_rdata(b_resp_rdata),
    .resp_fault(b_resp_fault), .resp_cause(b_resp_cause), .mem_req(b_mem_req), .mem_we(b_mem_we),
    .mem_addr(b_mem_addr), .mem_be(b_mem_be), .mem_wdata(b_mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack));

  typedef struct {
    logic        rd, wr;
    logic [1:0]  mode;
    logic        sgn;
    logic [31:0] addr, wdata, rdata;
    int          ack_dly;
  } req_t;

  typedef struct {
    int          nreq;
    logic        we;
    logic [31:0] maddr;
    logic [3:0]  be;
    logic [31:0] mwdata;
    logic [31:0] rdata;
    logic        fault;
    logic [1:0]  cause;
    int          lat;
  } res_t;

  typedef struct {
    logic        rd, wr;
    logic [1:0]  mode;
    logic        sgn;
    logic [31:0] addr, wdata, rdata;
    int          ack_dly;
    int          x_nreq;
    logic        x_we;
    logic [31:0] x_maddr;
    logic [3:0]  x_be, x_be_b;
    logic [31:0] x_mwdata, x_rdata, x_rdata_b;
    logic        x_fault;
    logic [1:0]  x_cause;
    int          x_lat;
  } vec_t;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Byte-level reference: memory is a row of bytes, lanes map by endianness.
  function automatic res_t model(input req_t r, input bit big);
    res_t e;
    int size, o, lo, ln;
    logic [31:0] v, byt;
    e = '{default: 0};
    size = (r.mode == `MEM_BYTE) ? 1 : (r.mode == `MEM_HALF) ? 2 : 4;
    if (r.rd && r.wr) begin
      e.fault = 1'b1; e.cause = 2'b11; e.lat = 1;
      return e;
    end
    if (TRAP && (int'(r.addr % 4) % size != 0)) begin
      e.fault = 1'b1; e.cause = 2'b01; e.lat = 1;
      return e;
    end
    o = int'(r.addr % 4);
    o = o - (o % size);
    lo = big ? (4 - o - size) : o;
    e.maddr = r.addr - (r.addr % 4);
    e.be = 4'(((1 << size) - 1) << lo);
    e.we = r.wr;
    e.mwdata = 32'd0;
    if (r.wr) for (int i = 0; i < 4; i++) e.mwdata[8*i +: 8] = r.wdata[8*(i % size) +: 8];
    v = 32'd0;
    if (r.rd) begin
      for (int j = 0; j < size; j++) begin
        ln = big ? (3 - (o + j)) : (o + j);
        byt = {24'd0, r.rdata[8*ln +: 8]};
        if (big) v = (v << 8) | byt;
        else     v = v | (byt << (8 * j));
      end
      if (r.sgn && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8 * size));
    end
    if (r.ack_dly >= TO) begin
      e.nreq = TO; e.fault = 1'b1; e.cause = 2'b10; e.lat = TO + 1; e.rdata = 32'd0;
    end else begin
      e.nreq = r.ack_dly + 1; e.rdata = v; e.lat = r.ack_dly + 2;
    end
    return e;
  endfunction

  // Issue one request (entered and left just after a falling edge) and record what both units did.
  task automatic run_txn(input req_t r, output res_t a, output res_t b, output bit held_ok, output bit tail_ok);
    int  cyc;
    bit  done;
    a = '{default: 0};
    b = '{default: 0};
    held_ok = 1'b1;
    tail_ok = 1'b0;
    done = 1'b0;
    cyc = 0;
    while (!a_req_ready && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    req_valid = 1'b1; req_read = r.rd; req_write = r.wr; req_mode = r.mode;
    req_signed = r.sgn; req_addr = r.addr; req_wdata = r.wdata; mem_rdata = r.rdata;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    for (int lat = 1; lat <= 30 && !done; lat++) begin
      if (a_resp_valid) begin
        a.lat = lat; a.rdata = a_resp_rdata; a.fault = a_resp_fault; a.cause = a_resp_cause;
        b.lat = lat; b.rdata = b_resp_rdata; b.fault = b_resp_fault; b.cause = b_resp_cause;
        if (b_resp_valid !== 1'b1 || a_mem_req !== 1'b0 || a_req_ready !== 1'b0) held_ok = 1'b0;
        mem_ack = 1'b0;
        done = 1'b1;
      end else begin
        if (a_mem_req) begin
          if (a.nreq == 0) begin
            a.we = a_mem_we; a.maddr = a_mem_addr; a.be = a_mem_be; a.mwdata = a_mem_wdata;
            b.be = b_mem_be;
          end else if (a_mem_we !== a.we || a_mem_addr !== a.maddr || a_mem_be !== a.be ||
                       a_mem_wdata !== a.mwdata || b_mem_be !== b.be) begin
            held_ok = 1'b0;
          end
          if (a_req_ready !== 1'b0) held_ok = 1'b0;
          a.nreq++;
          mem_ack = ((a.nreq - 1) == r.ack_dly);
        end else begin
          mem_ack = 1'b0;
        end
        if (b_mem_req) b.nreq++;
        @(posedge clk);
        @(negedge clk);
      end
    end
    mem_ack = 1'b0;
    if (done) begin
      @(posedge clk);
      @(negedge clk);
      tail_ok = (a_resp_valid === 1'b0) && (a_req_ready === 1'b1) && (a_mem_req === 1'b0);
    end
  endtask

  task automatic compare(input string tag, input res_t a, input res_t b, input bit held, input bit tail,
                         input res_t e, input logic [3:0] be_b, input logic [31:0] rdata_b);
    check({tag, ".latency"}, a.lat, e.lat);
    check({tag, ".mem_req_cycles"}, a.nreq, e.nreq);
    check({tag, ".be_mem_req_cycles"}, b.nreq, e.nreq);
    check({tag, ".fault"}, a.fault, e.fault);
    check({tag, ".cause"}, a.cause, e.cause);
    check({tag, ".rdata"}, a.rdata, e.rdata);
    check({tag, ".be_rdata"}, b.rdata, rdata_b);
    check({tag, ".held_and_single"}, held, 1'b1);
    check({tag, ".tail_idle"}, tail, 1'b1);
    if (e.nreq > 0) begin
      check({tag, ".mem_we"}, a.we, e.we);
      check({tag, ".mem_addr"}, a.maddr, e.maddr);
      check({tag, ".mem_be"}, a.be, e.be);
      check({tag, ".mem_wdata"}, a.mwdata, e.mwdata);
      check({tag, ".be_mem_be"}, b.be, be_b);
    end
  endtask

  vec_t vecs[12];

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    req_t r;
    res_t a, b, e, eb;
    bit   held, tail;
    int   k;

    vecs[0]  = '{1'b1, 1'b0, `MEM_WORD, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 2,
                 3, 1'b0, 32'h100, 4'hF, 4'hF, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 2'b00, 4};
    vecs[1]  = '{1'b0, 1'b1, `MEM_BYTE, 1'b0, 32'h103, 32'h000000A5, 32'h0, 0,
                 1, 1'b1, 32'h100, 4'h8, 4'h1, 32'hA5A5A5A5, 32'h0, 32'h0, 1'b0, 2'b00, 2};
    vecs[2]  = '{1'b1, 1'b0, `MEM_HALF, 1'b1, 32'h102, 32'h0, 32'h80010000, 1,
                 2, 1'b0, 32'h100, 4'hC, 4'h3, 32'h0, 32'hFFFF8001, 32'h0, 1'b0, 2'b00, 3};
    vecs[3]  = '{1'b1, 1'b0, `MEM_HALF, 1'b0, 32'h102, 32'h0, 32'h80010000, 0,
                 1, 1'b0, 32'h100, 4'hC, 4'h3, 32'h0, 32'h00008001, 32'h0, 1'b0, 2'b00, 2};
    vecs[4]  = '{1'b1, 1'b0, `MEM_BYTE, 1'b1, 32'h100, 32'h0, 32'h0000007F, 0,
                 1, 1'b0, 32'h100, 4'h1, 4'h8, 32'h0, 32'h0000007F, 32'h0, 1'b0, 2'b00, 2};
    vecs[5]  = '{1'b1, 1'b0, `MEM_BYTE, 1'b1, 32'h101, 32'h0, 32'h00008000, 0,
                 1, 1'b0, 32'h100, 4'h2, 4'h4, 32'h0, 32'hFFFFFF80, 32'h0, 1'b0, 2'b00, 2};
    vecs[6]  = '{1'b0, 1'b1, `MEM_HALF, 1'b0, 32'h102, 32'h1234ABCD, 32'h0, 1,
                 2, 1'b1, 32'h100, 4'hC, 4'h3, 32'hABCDABCD, 32'h0, 32'h0, 1'b0, 2'b00, 3};
    vecs[7]  = '{1'b0, 1'b1, `MEM_WORD, 1'b0, 32'h204, 32'hCAFEF00D, 32'h0, 3,
                 4, 1'b1, 32'h204, 4'hF, 4'hF, 32'hCAFEF00D, 32'h0, 32'h0, 1'b0, 2'b00, 5};
    vecs[8]  = '{1'b1, 1'b1, `MEM_WORD, 1'b0, 32'h300, 32'h0, 32'h0, 0,
                 0, 1'b0, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0, 32'h0, 1'b1, 2'b11, 1};
    vecs[9]  = '{1'b1, 1'b0, `MEM_WORD, 1'b0, 32'h40, 32'h0, 32'h12345678, 9,
                 4, 1'b0, 32'h40, 4'hF, 4'hF, 32'h0, 32'h0, 32'h0, 1'b1, 2'b10, 5};
    vecs[10] = '{1'b1, 1'b0, `MEM_BYTE, 1'b0, 32'h7, 32'h0, 32'hF0000000, 3,
                 4, 1'b0, 32'h4, 4'h8, 4'h1, 32'h0, 32'h000000F0, 32'h0, 1'b0, 2'b00, 5};
    vecs[11] = '{1'b1, 1'b0, `MEM_HALF, 1'b1, 32'h100, 32'h0, 32'h1234FFFE, 0,
                 1, 1'b0, 32'h100, 4'h3, 4'hC, 32'h0, 32'hFFFFFFFE, 32'h00001234, 1'b0, 2'b00, 2};

    // Reset values while reset is held.
    #3;
    check("reset.mem_req", a_mem_req, 1'b0);
    check("reset.resp_valid", a_resp_valid, 1'b0);
    check("reset.resp_fault", a_resp_fault, 1'b0);
    check("reset.resp_rdata", a_resp_rdata, 32'h0);
    check("reset.mem_be", a_mem_be, 4'h0);
    check("reset.mem_addr", a_mem_addr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset.req_ready", a_req_ready, 1'b1);
    check("reset.be_req_ready", b_req_ready, 1'b1);

    // Valid without read or write is ignored.
    req_valid = 1'b1; req_read = 1'b0; req_write = 1'b0; req_addr = 32'h100;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("ignored.mem_req", a_mem_req, 1'b0);
      check("ignored.resp_valid", a_resp_valid, 1'b0);
      check("ignored.req_ready", a_req_ready, 1'b1);
    end
    req_valid = 1'b0;

    // Table vectors.
    for (int i = 0; i < 12; i++) begin
      r = '{vecs[i].rd, vecs[i].wr, vecs[i].mode, vecs[i].sgn, vecs[i].addr, vecs[i].wdata,
            vecs[i].rdata, vecs[i].ack_dly};
      e = '{vecs[i].x_nreq, vecs[i].x_we, vecs[i].x_maddr, vecs[i].x_be, vecs[i].x_mwdata,
            vecs[i].x_rdata, vecs[i].x_fault, vecs[i].x_cause, vecs[i].x_lat};
      run_txn(r, a, b, held, tail);
      compare($sformatf("vec%0d", i), a, b, held, tail, e, vecs[i].x_be_b, vecs[i].x_rdata_b);
    end

    // Misaligned word load: trapped, or forced down to the containing word.
    r = '{1'b1, 1'b0, `MEM_WORD, 1'b0, 32'h101, 32'h0, 32'h11223344, 0};
    run_txn(r, a, b, held, tail);
`ifdef MEM_ALIGN_TRAP_EN
    e = '{0, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b1, 2'b01, 1};
    compare("misalign_lw", a, b, held, tail, e, 4'h0, 32'h0);
`else
    e = '{1, 1'b0, 32'h100, 4'hF, 32'h0, 32'h11223344, 1'b0, 2'b00, 2};
    compare("misalign_lw", a, b, held, tail, e, 4'hF, 32'h11223344);
`endif

    // Misaligned signed half load at 0x103.
    r = '{1'b1, 1'b0, `MEM_HALF, 1'b1, 32'h103, 32'h0, 32'hAABB7788, 1};
    run_txn(r, a, b, held, tail);
`ifdef MEM_ALIGN_TRAP_EN
    e = '{0, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b1, 2'b01, 1};
    compare("misalign_lh", a, b, held, tail, e, 4'h0, 32'h0);
`else
    e = '{2, 1'b0, 32'h100, 4'hC, 32'h0, 32'hFFFFAABB, 1'b0, 2'b00, 3};
    compare("misalign_lh", a, b, held, tail, e, 4'h3, 32'h00007788);
`endif

    // Reset in the middle of a memory wait.
    req_valid = 1'b1; req_read = 1'b1; req_write = 1'b0; req_mode = `MEM_WORD; req_addr = 32'h80;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("rst_mid.mem_req_before", a_mem_req, 1'b1);
    @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid.mem_req_async", a_mem_req, 1'b0);
    check("rst_mid.be_mem_req_async", b_mem_req, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_ack = 1'b1;
    mem_rdata = 32'hBADC0DE0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("rst_mid.no_resp", a_resp_valid, 1'b0);
      check("rst_mid.no_mem_req", a_mem_req, 1'b0);
      check("rst_mid.req_ready", a_req_ready, 1'b1);
    end
    mem_ack = 1'b0;

    // Randomized transactions against the model.
    for (int i = 0; i < 150; i++) begin
      k = $urandom_range(0, 9);
      r.rd = (k == 0) || (k < 5);
      r.wr = (k == 0) || (k >= 5);
      k = $urandom_range(0, 2);
      r.mode = (k == 0) ? `MEM_BYTE : (k == 1) ? `MEM_HALF : `MEM_WORD;
      r.sgn = 1'($urandom_range(0, 1));
      r.addr = $urandom();
      r.wdata = $urandom();
      r.rdata = $urandom();
      r.ack_dly = $urandom_range(0, TO + 1);
      e = model(r, 1'b0);
      eb = model(r, 1'b1);
      run_txn(r, a, b, held, tail);
      compare($sformatf("rand%0d", i), a, b, held, tail, e, eb.be, eb.rdata);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
